// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
package uart_pkg;

    localparam int unsigned MIN_SYMBOL_WIDTH = 4;

    localparam logic PARITY_MODE_EVEN = 1'b0;
    localparam logic PARITY_MODE_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

    // Clocks per bit actually used: symbol_width clamped to the minimum.
    function automatic logic [15:0] eff_width(input logic [15:0] sw);
        return (sw < 16'(MIN_SYMBOL_WIDTH)) ? 16'(MIN_SYMBOL_WIDTH) : sw;
    endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit timer: latches the per-frame bit width and flags half-bit and
// full-bit points relative to the last load/clear.
module uart_rx_bit_timer
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [15:0] symbol_width,
    output logic        half_tick,
    output logic        full_tick
);

    logic [15:0] n_lat;
    logic [15:0] cnt;

    assign half_tick = (cnt == ((n_lat >> 1) - 16'd1));
    assign full_tick = (cnt == (n_lat - 16'd1));

    // Latch N at frame start; restart the count whenever a tick is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_lat <= 16'(MIN_SYMBOL_WIDTH);
            cnt   <= '0;
        end else if (load) begin
            n_lat <= eff_width(symbol_width);
            cnt   <= '0;
        end else if (clear) begin
            cnt   <= '0;
        end else begin
            cnt   <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with start-glitch rejection, frame error
// detection and break (WAIT_HIGH) handling.
// Optional feature macro: UART_RX_PARITY_EN (one parity bit after data).
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       symbol_width,
    input  logic              rx,
    output logic              recv_req,
    output logic [DATA_W-1:0] d_out,
    output logic              frame_err,
    output logic              parity_err
);

    localparam logic [3:0] DATA_LAST = 4'(DATA_W - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    if (DATA_W < 5 || DATA_W > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_cfg
        $error("uart_rx_cfg: unsupported parameter combination");
    end

    logic              rx_meta;
    logic              rxs;
    rx_state_t         state;
    logic [3:0]        bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              ferr_acc;
    logic              stop_bad;
    logic              load;
    logic              clear;
    logic              half_tick;
    logic              full_tick;
`ifdef UART_RX_PARITY_EN
    logic              par_acc;
    logic              par_bad;
`endif

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign load     = (state == IDLE) && !rxs;
    assign stop_bad = ferr_acc | ~rxs;

    // Restart the bit timer whenever the FSM consumes a sample point.
    always_comb begin
        clear = 1'b0;
        case (state)
            START:       clear = half_tick;
            DATA, STOP:  clear = full_tick;
`ifdef UART_RX_PARITY_EN
            PARITY:      clear = full_tick;
`endif
            default:     clear = 1'b0;
        endcase
    end

    uart_rx_bit_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .clear        (clear),
        .symbol_width (symbol_width),
        .half_tick    (half_tick),
        .full_tick    (full_tick)
    );

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    // Receive FSM with registered strobe, data and error outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            ferr_acc   <= 1'b0;
            recv_req   <= 1'b0;
            d_out      <= '0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_acc    <= 1'b0;
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            recv_req   <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state    <= START;
                        bit_cnt  <= '0;
                        ferr_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        // Odd mode seeds with 1 so a correct frame folds to 0.
                        par_acc  <= PARITY_ODD[0];
                        par_bad  <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (half_tick) begin
                        state <= rxs ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (full_tick) begin
                        shreg <= {rxs, shreg[DATA_W-1:1]};
`ifdef UART_RX_PARITY_EN
                        par_acc <= par_acc ^ rxs;
`endif
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (full_tick) begin
                        par_bad <= par_acc ^ rxs;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (full_tick) begin
                        if (bit_cnt == STOP_LAST) begin
                            recv_req   <= 1'b1;
                            d_out      <= shreg;
                            frame_err  <= stop_bad;
`ifdef UART_RX_PARITY_EN
                            parity_err <= par_bad;
`endif
                            state      <= stop_bad ? WAIT_HIGH : IDLE;
                        end else begin
                            ferr_acc <= stop_bad;
                            bit_cnt  <= bit_cnt + 4'd1;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
